// File: rtl/miter_sweep_if.sv
// Handshake and result bundle between the miter sweep controller and the miter it drives.
// The controller connects through the slave modport. Its stimulus/bench side uses master.
interface miter_sweep_if #(
  parameter int NX = 2,
  parameter int NY = 2,
  parameter int NG = 2
);
  localparam int W = NX + NY + NG;

  logic          start;
  logic          abort;
  logic          miter_out;
  logic [NX-1:0] x_vec;
  logic [NY-1:0] y_vec;
  logic [NG-1:0] g_vec;
  logic          busy;
  logic          done;
  logic          cex_found;
  logic [W-1:0]  cex_vec;
  logic [W:0]    cex_count;

  modport master (
    output start, abort, miter_out,
    input  x_vec, y_vec, g_vec, busy, done, cex_found, cex_vec, cex_count
  );

  modport slave (
    input  start, abort, miter_out,
    output x_vec, y_vec, g_vec, busy, done, cex_found, cex_vec, cex_count
  );
endinterface

// File: rtl/miter_sweep_ctrl.sv
// Exhaustive sweep of the miter input space, recording the first counterexample and a hit count.
// Optional macro MITER_SWEEP_EARLY_STOP_EN ends the sweep on the first counterexample.
//
// state | meaning
// IDLE  | after reset, waiting for start
// SWEEP | driving cnt onto the miter, sampling miter_out each cycle
// DONE  | results held until the next accepted start
module miter_sweep_ctrl #(
  parameter int NX = 2,
  parameter int NY = 2,
  parameter int NG = 2
) (
  input logic           clk,
  input logic           rst_n,
  miter_sweep_if.slave  bus
);
  localparam int W = NX + NY + NG;
  localparam logic [W:0] CNT_MAX = {1'b1, {W{1'b0}}};

  generate
    if (W < 1 || W > 16) begin : g_bad_width
      $error("miter_sweep_ctrl: NX+NY+NG must be in 1..16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] cnt;
  logic         cex_found;
  logic [W-1:0] cex_vec;
  logic [W:0]   cex_count;
  logic         clr;
  logic         cnt_inc;
  logic         hit;
  logic         cnt_last;

  assign cnt_last = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    cnt_inc   = 1'b0;
    hit       = 1'b0;
    bus.busy  = (state == SWEEP);
    bus.done  = (state == DONE);
    case (state)
      IDLE, DONE: begin
        if (bus.start && !bus.abort) begin
          clr       = 1'b1;
          state_nxt = SWEEP;
        end
      end
      SWEEP: begin
        // an abort cycle is not evaluated: no sample, no count step
        if (bus.abort) begin
          state_nxt = DONE;
        end else begin
          hit = bus.miter_out;
`ifdef MITER_SWEEP_EARLY_STOP_EN
          if (bus.miter_out || cnt_last) state_nxt = DONE;
          else                           cnt_inc   = 1'b1;
`else
          if (cnt_last) state_nxt = DONE;
          else          cnt_inc   = 1'b1;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      cex_found <= 1'b0;
      cex_vec   <= '0;
      cex_count <= '0;
    end else if (clr) begin
      cnt       <= '0;
      cex_found <= 1'b0;
      cex_vec   <= '0;
      cex_count <= '0;
    end else begin
      if (cnt_inc) cnt <= cnt + 1'b1;
      if (hit) begin
        if (!cex_found) begin
          cex_found <= 1'b1;
          cex_vec   <= cnt;
        end
        if (cex_count != CNT_MAX) cex_count <= cex_count + 1'b1;
      end
    end
  end

  assign bus.x_vec     = cnt[NX-1:0];
  assign bus.y_vec     = cnt[NX+NY-1:NX];
  assign bus.g_vec     = cnt[W-1:NX+NY];
  assign bus.cex_found = cex_found;
  assign bus.cex_vec   = cex_vec;
  assign bus.cex_count = cex_count;
endmodule

// File: tb/tb_miter_sweep_ctrl.sv
// Directed bench for miter_sweep_ctrl at NX=NY=NG=2, with a small miter model selected by mode.
module tb_miter_sweep_ctrl;
  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   mode     = 0;
  int   n;
  int   saw_done;

  miter_sweep_if #(.NX(2), .NY(2), .NG(2)) bus ();

  miter_sweep_ctrl #(.NX(2), .NY(2), .NG(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [5:0] vec;
  assign vec = {bus.g_vec, bus.y_vec, bus.x_vec};

  always_comb begin
    case (mode)
      1:       bus.miter_out = (vec == 6'h25);
      2:       bus.miter_out = (vec >= 6'h10);
      3:       bus.miter_out = (vec == 6'h08);
      default: bus.miter_out = 1'b0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // called at a negedge: pulse start over one posedge, then count negedges seen with busy high
  task automatic start_and_count(output int cycles);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cycles = 0;
    while (bus.busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_done",  32'(bus.done), 32'd0);
    check("rst_vec",   32'(vec), 32'd0);
    check("rst_cex",   32'(bus.cex_found), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // clean sweep
    mode = 0;
    start_and_count(n);
    check("clean_cycles", 32'(n), 32'd64);
    check("clean_done",   32'(bus.done), 32'd1);
    check("clean_found",  32'(bus.cex_found), 32'd0);
    check("clean_count",  32'(bus.cex_count), 32'd0);
    check("clean_cnt",    32'(vec), 32'h3f);

    // single counterexample at 0x25
    mode = 1;
    start_and_count(n);
`ifdef MITER_SWEEP_EARLY_STOP_EN
    check("single_cycles", 32'(n), 32'd38);
`else
    check("single_cycles", 32'(n), 32'd64);
`endif
    check("single_done",  32'(bus.done), 32'd1);
    check("single_found", 32'(bus.cex_found), 32'd1);
    check("single_vec",   32'(bus.cex_vec), 32'h25);
    check("single_count", 32'(bus.cex_count), 32'd1);

    // start with abort in DONE is an abort: nothing changes
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    check("coll_done",  32'(bus.done), 32'd1);
    check("coll_busy",  32'(bus.busy), 32'd0);
    check("coll_vec",   32'(bus.cex_vec), 32'h25);
    check("coll_count", 32'(bus.cex_count), 32'd1);

    // abort at cnt 0x08 while miter_out is high
    mode = 3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (vec != 6'h08 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("abort_reach", 32'(n), 32'd8);
    check("abort_miter", 32'(bus.miter_out), 32'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_done",  32'(bus.done), 32'd1);
    check("abort_busy",  32'(bus.busy), 32'd0);
    check("abort_found", 32'(bus.cex_found), 32'd0);
    check("abort_count", 32'(bus.cex_count), 32'd0);
    check("abort_cnt",   32'(vec), 32'h08);
    @(negedge clk);
    check("abort_hold",  32'(vec), 32'h08);

    // miter high for cnt >= 0x10
    mode = 2;
    start_and_count(n);
`ifdef MITER_SWEEP_EARLY_STOP_EN
    check("upper_cycles", 32'(n), 32'd17);
    check("upper_count",  32'(bus.cex_count), 32'd1);
`else
    check("upper_cycles", 32'(n), 32'd64);
    check("upper_count",  32'(bus.cex_count), 32'd48);
`endif
    check("upper_done",  32'(bus.done), 32'd1);
    check("upper_found", 32'(bus.cex_found), 32'd1);
    check("upper_vec",   32'(bus.cex_vec), 32'h10);

    // restart from DONE, with a start pulse mid-sweep that must be ignored
    mode = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_found", 32'(bus.cex_found), 32'd0);
    check("restart_count", 32'(bus.cex_count), 32'd0);
    check("restart_vec",   32'(bus.cex_vec), 32'd0);
    repeat (10) @(negedge clk);
    check("busy_cnt10", 32'(vec), 32'd10);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_start_ign", 32'(vec), 32'd11);
    n = 11;
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("restart_cycles", 32'(n), 32'd64);
    check("restart_done",   32'(bus.done), 32'd1);
    check("restart_cex",    32'(bus.cex_found), 32'd0);

    // asynchronous reset in the middle of a sweep
    mode = 1;
    start_and_count(n);
    mode = 2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy",  32'(bus.busy), 32'd0);
    check("arst_done",  32'(bus.done), 32'd0);
    check("arst_vec",   32'(vec), 32'd0);
    check("arst_found", 32'(bus.cex_found), 32'd0);
    check("arst_cvec",  32'(bus.cex_vec), 32'd0);
    check("arst_count", 32'(bus.cex_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1;
    end
    check("post_rst_quiet", 32'(saw_done), 32'd0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("post_rst_start", 32'(bus.busy), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/miter_sweep_ctrl.md
MITER_SWEEP_CTRL -- requirements
Module: miter_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter NX, default 2: width of the universal input vector x.
REQ-002 The block SHALL have parameter NY, default 2: width of the original existential output vector y_orig.
REQ-003 The block SHALL have parameter NG, default 2: width of the candidate-function input vector g.
REQ-004 The block SHALL derive W = NX+NY+NG; legal range is 1..16, and elaboration SHALL fail outside it.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  begin a sweep; sampled in IDLE or DONE only.
REQ-008 abort  in  1  terminate a sweep in progress.
REQ-009 miter_out  in  1  combinational miter result (valid_orig & ~valid_syn) for the currently driven vector.
REQ-010 x_vec  out  NX  universal inputs to the miter, taken from cnt[NX-1:0].
REQ-011 y_vec  out  NY  original outputs to the miter, taken from cnt[NX+NY-1:NX].
REQ-012 g_vec  out  NG  candidate inputs to the miter, taken from cnt[W-1:NX+NY].
REQ-013 busy  out  1  high while in SWEEP.
REQ-014 done  out  1  high while in DONE.
REQ-015 cex_found  out  1  at least one counterexample was seen in the last sweep.
REQ-016 cex_vec  out  W  counter value of the first counterexample.
REQ-017 cex_count  out  W+1  number of counterexamples found.

Function
REQ-018 The block SHALL implement the states IDLE, SWEEP and DONE, held in a registered state variable.
REQ-019 The block SHALL hold a W-bit counter cnt, and x_vec/y_vec/g_vec SHALL be driven from the registered cnt.
REQ-020 In IDLE or DONE, start=1 with abort=0 SHALL clear cnt, cex_found, cex_vec and cex_count and move to SWEEP on the next edge.
REQ-021 In SWEEP, miter_out SHALL be sampled every cycle against the vector driven that cycle, giving zero-cycle evaluation latency.
REQ-022 When miter_out=1 and cex_found=0, the block SHALL set cex_found and capture cnt into cex_vec in the same edge.
REQ-023 Each sampled miter_out=1 SHALL increment cex_count, saturating at 2^W.
REQ-024 When cnt equals all-ones, that cycle SHALL still be evaluated, then the block SHALL move to DONE; cnt SHALL NOT wrap to 0 while in SWEEP.
REQ-025 A sweep SHALL take exactly 2^W SWEEP cycles when not terminated early.
REQ-026 In SWEEP, abort=1 SHALL move to DONE on the next edge and SHALL discard that cycle's miter_out sample; cnt SHALL freeze.
REQ-027 In SWEEP, start SHALL be ignored.
REQ-028 In IDLE or DONE, start and abort asserted together SHALL be treated as abort: the state is unchanged.
REQ-029 In DONE, all result outputs SHALL hold until the next accepted start.
REQ-030 The outputs busy and done SHALL be decoded from registered state only, and SHALL never both be high.

Reset
REQ-031 Asserting rst_n low SHALL force the following immediately (asynchronously): state to IDLE; cnt, cex_found, cex_vec and cex_count to 0; busy and done to 0. x_vec, y_vec and g_vec therefore read 0.
REQ-032 A reset asserted mid-sweep SHALL discard all partial results, and no done indication SHALL follow.
REQ-033 After deassertion, the first accepted start SHALL require one full clock edge with rst_n high.

Configuration
REQ-034 The macro MITER_SWEEP_EARLY_STOP_EN SHALL select the early-stop behaviour.
- Defined: the first counterexample SHALL move SWEEP to DONE on that same edge; cex_count ends at 1.
- Undefined: the sweep SHALL continue through the full space and count every counterexample.
- In both cases cex_vec SHALL hold the first counterexample.

Verification
REQ-035 Reset: rst_n low mid-sweep -> state IDLE, all outputs 0 asynchronously, with no clock edge.
REQ-036 Clean sweep: NX=NY=NG=2 with miter_out tied 0, start pulse -> busy for exactly 64 cycles, then done=1, cex_found=0, cex_count=0.
REQ-037 Single counterexample: miter_out=1 only when cnt=6'h25, macro undefined -> done after 64 cycles, cex_found=1, cex_vec=6'h25, cex_count=1.
REQ-038 Early stop: miter_out=1 for cnt>=6'h10, macro defined -> done one edge after cnt=6'h10, cex_vec=6'h10, cex_count=1; macro undefined -> cex_count=48.
REQ-039 Abort: abort at cnt=6'h08 with miter_out=1 that cycle -> DONE next edge, cex_found=0, cnt frozen at 6'h08.
REQ-040 Start collision: start while busy is ignored; start with abort in DONE leaves the old results unchanged.
REQ-041 Restart: start from DONE clears all results and a second sweep reproduces the REQ-036 result.
